// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: word-addressed RAM behind a req/ack FSM with WAIT_STATES extra cycles per access.
// Optional SYNC_RAM_PARITY_EN stores one even-parity bit per byte lane and flags mismatches on reads.
module sync_ram_ctrl #(
  parameter int RAM_SIZE    = 256,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        req,
  input  logic                        we,
  input  logic [$clog2(RAM_SIZE)-1:0] address,
  input  logic [DATA_WIDTH/8-1:0]     byte_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        ack,
  output logic                        busy,
  output logic                        parity_err
);

  localparam int AW    = $clog2(RAM_SIZE);
  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [AW:0] LIMIT = (AW + 1)'(RAM_SIZE);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
    logic [LANES-1:0] p;
    for (int i = 0; i < LANES; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic                    we_r;
  logic [AW-1:0]           addr_r;
  logic [LANES-1:0]        be_r;
  logic [DATA_WIDTH-1:0]   din_r;
  logic [DATA_WIDTH-1:0]   data_out_r;
  logic                    ack_r;
  logic                    busy_r;
  logic                    parity_err_r;

  logic [DATA_WIDTH-1:0]   mem_r [RAM_SIZE];

  logic                    enter_done_s;
  logic                    acc_we_s;
  logic [AW-1:0]           acc_addr_s;
  logic [LANES-1:0]        acc_be_s;
  logic [DATA_WIDTH-1:0]   acc_din_s;
  logic                    in_range_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic [LANES-1:0]        mismatch_s;

  // Detect the edge entering DONE; with no wait states the access uses the values being latched now
  always_comb begin
    enter_done_s = 1'b0;
    acc_we_s     = we_r;
    acc_addr_s   = addr_r;
    acc_be_s     = be_r;
    acc_din_s    = din_r;
    if (state_r == IDLE) begin
      enter_done_s = req && (WS == 4'd0);
      acc_we_s     = we;
      acc_addr_s   = address;
      acc_be_s     = byte_en;
      acc_din_s    = data_in;
    end else if (state_r == WAIT) begin
      enter_done_s = (cnt_r == 4'd1);
    end else begin
      enter_done_s = 1'b0;
    end
  end

  // Out-of-range addresses read as zero and never touch the array
  always_comb begin
    in_range_s = ({1'b0, acc_addr_s} < LIMIT);
    if (in_range_s) begin
      rd_word_s = mem_r[acc_addr_s];
    end else begin
      rd_word_s = '0;
    end
  end

`ifdef SYNC_RAM_PARITY_EN
  logic [LANES-1:0] par_r [RAM_SIZE];

  // Parity bits follow their lane's write enable
  always_ff @(posedge clk) begin
    if (enter_done_s && acc_we_s && in_range_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (acc_be_s[i]) begin
          par_r[acc_addr_s][i] <= ^acc_din_s[8*i +: 8];
        end
      end
    end
  end

  // Lane-wise comparison of recomputed against stored parity
  always_comb begin
    if (in_range_s) begin
      mismatch_s = lane_parity(rd_word_s) ^ par_r[acc_addr_s];
    end else begin
      mismatch_s = '0;
    end
  end
`else
  assign mismatch_s = '0;
`endif

  // Lane-masked array write; no reset so contents survive arst
  always_ff @(posedge clk) begin
    if (enter_done_s && acc_we_s && in_range_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (acc_be_s[i]) begin
          mem_r[acc_addr_s][8*i +: 8] <= acc_din_s[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered ack/busy and read-data capture
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      be_r         <= '0;
      din_r        <= '0;
      data_out_r   <= '0;
      ack_r        <= 1'b0;
      busy_r       <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= 1'b0;
          if (req) begin
            we_r   <= we;
            addr_r <= address;
            be_r   <= byte_en;
            din_r  <= data_in;
            busy_r <= 1'b1;
            if (WS == 4'd0) begin
              state_r <= DONE;
              ack_r   <= 1'b1;
            end else begin
              state_r <= WAIT;
              cnt_r   <= WS;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r <= DONE;
            ack_r   <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
      if (enter_done_s && !acc_we_s) begin
        data_out_r   <= rd_word_s;
        parity_err_r <= |mismatch_s;
      end
    end
  end

  assign data_out   = data_out_r;
  assign ack        = ack_r;
  assign busy       = busy_r;
  assign parity_err = parity_err_r;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Scoreboard bench for sync_ram_ctrl: three instances (256/WS=2, 200/WS=2, 256/WS=0) share data inputs.
// Expected read words are queued at stimulus time from a reference model and popped at ack.
module tb_sync_ram_ctrl;

  logic        clk = 1'b0;
  logic        arst;
  logic [2:0]  req_v;
  logic        we;
  logic [7:0]  address;
  logic [1:0]  byte_en;
  logic [15:0] data_in;
  logic [15:0] dout_v [3];
  logic [2:0]  ack_v;
  logic [2:0]  busy_v;
  logic [2:0]  perr_v;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model [3][256];
  logic [15:0] exp_q [$];
  logic [15:0] last_rd [3];
  logic        last_perr [3];

  sync_ram_ctrl #(.RAM_SIZE(256), .DATA_WIDTH(16), .WAIT_STATES(2)) dut0 (
    .clk(clk), .arst(arst), .req(req_v[0]), .we(we), .address(address), .byte_en(byte_en),
    .data_in(data_in), .data_out(dout_v[0]), .ack(ack_v[0]), .busy(busy_v[0]), .parity_err(perr_v[0]));

  sync_ram_ctrl #(.RAM_SIZE(200), .DATA_WIDTH(16), .WAIT_STATES(2)) dut1 (
    .clk(clk), .arst(arst), .req(req_v[1]), .we(we), .address(address), .byte_en(byte_en),
    .data_in(data_in), .data_out(dout_v[1]), .ack(ack_v[1]), .busy(busy_v[1]), .parity_err(perr_v[1]));

  sync_ram_ctrl #(.RAM_SIZE(256), .DATA_WIDTH(16), .WAIT_STATES(0)) dut2 (
    .clk(clk), .arst(arst), .req(req_v[2]), .we(we), .address(address), .byte_en(byte_en),
    .data_in(data_in), .data_out(dout_v[2]), .ack(ack_v[2]), .busy(busy_v[2]), .parity_err(perr_v[2]));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int k, input logic w, input logic [7:0] a, input logic [1:0] be,
                        input logic [15:0] d, input logic exp_perr);
    int ws;
    int n;
    int nbusy;
    int lim;
    ws  = (k == 2) ? 0 : 2;
    lim = (k == 1) ? 200 : 256;
    if (!w) begin
      if (int'(a) >= lim) exp_q.push_back(16'h0000);
      else exp_q.push_back(model[k][a]);
    end else if (int'(a) < lim) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) model[k][a][8*i +: 8] = d[8*i +: 8];
      end
    end
    we = w; address = a; byte_en = be; data_in = d;
    req_v[k] = 1'b1;
    n = 0;
    nbusy = 0;
    while (n < 20) begin
      step();
      n++;
      req_v[k] = 1'b0;
      if (busy_v[k]) nbusy++;
      if (ack_v[k]) break;
      // scramble inputs while busy: only the latched copy may matter
      we = ~w; address = a ^ 8'h55; byte_en = ~be; data_in = ~d;
    end
    n_tests++;
    if (ack_v[k] !== 1'b1 || n != ws + 1) begin
      n_fail++;
      $display("FAIL ack_latency dut%0d addr=%h got=%0d want=%0d", k, a, n, ws + 1);
    end
    n_tests++;
    if (nbusy != ws + 1) begin
      n_fail++;
      $display("FAIL busy_cycles dut%0d got=%0d want=%0d", k, nbusy, ws + 1);
    end
    if (!w) begin
      last_rd[k]   = exp_q.pop_front();
      last_perr[k] = exp_perr;
    end
    n_tests++;
    if (dout_v[k] !== last_rd[k]) begin
      n_fail++;
      $display("FAIL data_out dut%0d we=%b addr=%h got=%h want=%h", k, w, a, dout_v[k], last_rd[k]);
    end
    n_tests++;
    if (perr_v[k] !== last_perr[k]) begin
      n_fail++;
      $display("FAIL parity_err dut%0d addr=%h got=%b want=%b", k, a, perr_v[k], last_perr[k]);
    end
    step();
    n_tests++;
    if (ack_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_pulse dut%0d ack=%b busy=%b want 0 0", k, ack_v[k], busy_v[k]);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (ack_v[k] !== 1'b0 || busy_v[k] !== 1'b0 || perr_v[k] !== 1'b0 || dout_v[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL %s dut%0d ack=%b busy=%b perr=%b dout=%h want all 0",
                 name, k, ack_v[k], busy_v[k], perr_v[k], dout_v[k]);
      end
      last_rd[k]   = 16'h0000;
      last_perr[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    arst = 1'b0; req_v = 3'b000; we = 1'b0; address = 8'h00; byte_en = 2'b00; data_in = 16'h0000;
    #2 arst = 1'b1;
    step();
    step();
    check_zero_outputs("reset_state");
    arst = 1'b0;
  endtask

  task automatic test_basic();
    access(0, 1'b1, 8'h10, 2'b11, 16'hBEEF, 1'b0);
    access(0, 1'b0, 8'h10, 2'b00, 16'h0000, 1'b0);
    access(2, 1'b1, 8'h10, 2'b11, 16'hC0DE, 1'b0);
    access(2, 1'b0, 8'h10, 2'b11, 16'h0000, 1'b0);
    access(1, 1'b1, 8'h00, 2'b11, 16'h0F0F, 1'b0);
    access(1, 1'b0, 8'h00, 2'b01, 16'h0000, 1'b0);
  endtask

  task automatic test_byte_lanes();
    access(0, 1'b1, 8'h05, 2'b11, 16'hBEEF, 1'b0);
    access(0, 1'b1, 8'h05, 2'b01, 16'h1234, 1'b0);
    access(0, 1'b0, 8'h05, 2'b00, 16'h0000, 1'b0);
    n_tests++;
    if (dout_v[0] !== 16'hBE34) begin
      n_fail++;
      $display("FAIL lane_merge got=%h want=%h", dout_v[0], 16'hBE34);
    end
    access(0, 1'b1, 8'h05, 2'b10, 16'hA5FF, 1'b0);
    access(0, 1'b1, 8'h05, 2'b00, 16'hFFFF, 1'b0);
    access(0, 1'b0, 8'h05, 2'b11, 16'h0000, 1'b0);
    access(2, 1'b1, 8'h06, 2'b11, 16'h1122, 1'b0);
    access(2, 1'b1, 8'h06, 2'b10, 16'h99AA, 1'b0);
    access(2, 1'b0, 8'h06, 2'b00, 16'h0000, 1'b0);
  endtask

  task automatic test_ignore_busy();
    int nack;
    logic [15:0] got;
    access(0, 1'b1, 8'h07, 2'b11, 16'h7777, 1'b0);
    access(0, 1'b1, 8'h08, 2'b11, 16'h8888, 1'b0);
    nack = 0;
    got  = 16'h0000;
    we = 1'b0; address = 8'h07; byte_en = 2'b11; data_in = 16'h0000;
    req_v[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      if (ack_v[0]) begin
        nack++;
        got = dout_v[0];
      end
      if (c == 0) begin
        we = 1'b1; address = 8'h08; data_in = 16'hDEAD; byte_en = 2'b11;
      end else if (c == 3) begin
        req_v[0] = 1'b0;
      end
    end
    req_v[0] = 1'b0;
    last_rd[0] = model[0][7];
    n_tests++;
    if (nack != 1) begin
      n_fail++;
      $display("FAIL ignore_busy_acks got=%0d want=1", nack);
    end
    n_tests++;
    if (got !== 16'h7777) begin
      n_fail++;
      $display("FAIL ignore_busy_data got=%h want=%h", got, 16'h7777);
    end
    access(0, 1'b0, 8'h08, 2'b11, 16'h0000, 1'b0);
  endtask

  task automatic test_out_of_range();
    access(1, 1'b1, 8'd10,  2'b11, 16'h1010, 1'b0);
    access(1, 1'b1, 8'd82,  2'b11, 16'h8282, 1'b0);
    access(1, 1'b1, 8'd199, 2'b11, 16'hC199, 1'b0);
    access(1, 1'b0, 8'd10,  2'b11, 16'h0000, 1'b0);
    access(1, 1'b1, 8'd210, 2'b11, 16'hAAAA, 1'b0);
    access(1, 1'b0, 8'd210, 2'b11, 16'h0000, 1'b0);
    n_tests++;
    if (dout_v[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL oor_read got=%h want=%h", dout_v[1], 16'h0000);
    end
    access(1, 1'b0, 8'd10,  2'b11, 16'h0000, 1'b0);
    access(1, 1'b0, 8'd82,  2'b11, 16'h0000, 1'b0);
    access(1, 1'b0, 8'd199, 2'b11, 16'h0000, 1'b0);
  endtask

  task automatic test_abort();
    int nack;
    access(0, 1'b1, 8'h03, 2'b11, 16'h1111, 1'b0);
    access(0, 1'b0, 8'h03, 2'b11, 16'h0000, 1'b0);
    we = 1'b1; address = 8'h03; byte_en = 2'b11; data_in = 16'h5555;
    req_v[0] = 1'b1;
    step();
    req_v[0] = 1'b0;
    n_tests++;
    if (busy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_wait busy=%b want=1", busy_v[0]);
    end
    #2 arst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    nack = 0;
    step();
    if (ack_v[0]) nack++;
    step();
    if (ack_v[0]) nack++;
    arst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ack_v[0]) nack++;
    end
    n_tests++;
    if (nack != 0) begin
      n_fail++;
      $display("FAIL abort_no_ack got=%0d want=0", nack);
    end
    access(0, 1'b0, 8'h03, 2'b11, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int k;
    for (int a = 0; a < 8; a++) begin
      access(0, 1'b1, 8'h40 + 8'(a), 2'b11, 16'(a * 16'h1357 + 16'h0101), 1'b0);
      access(2, 1'b1, 8'h40 + 8'(a), 2'b11, 16'(a * 16'h2468 + 16'h0202), 1'b0);
    end
    for (int i = 0; i < 24; i++) begin
      k = (i % 2 == 1) ? 2 : 0;
      access(k, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 16'($urandom), 1'b0);
    end
  endtask

  task automatic test_parity();
`ifdef SYNC_RAM_PARITY_EN
    access(0, 1'b1, 8'h09, 2'b11, 16'h00A5, 1'b0);
    access(0, 1'b1, 8'h0A, 2'b11, 16'h3C3C, 1'b0);
    dut0.mem_r[9][0] = ~dut0.mem_r[9][0];
    model[0][9][0]   = ~model[0][9][0];
    access(0, 1'b0, 8'h09, 2'b11, 16'h0000, 1'b1);
    access(0, 1'b0, 8'h0A, 2'b11, 16'h0000, 1'b0);
`else
    access(0, 1'b1, 8'h09, 2'b11, 16'h00A5, 1'b0);
    access(0, 1'b0, 8'h09, 2'b11, 16'h0000, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_ignore_busy();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_ram_ctrl.md
SYNC_RAM_CTRL -- requirements
Module: sync_ram_ctrl

Interface
REQ-001 SHALL have parameter: RAM_SIZE, 256, number of words; need not be a power of two.
REQ-002 SHALL have parameter: DATA_WIDTH, 8, word width in bits; multiple of 8.
REQ-003 SHALL have parameter: WAIT_STATES, 0, extra cycles inserted per access (0..15).
REQ-004 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: arst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: req  in  1  access request, sampled in IDLE only.
REQ-007 SHALL have port: we  in  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port: address  in  $clog2(RAM_SIZE)  word address; sampled with req.
REQ-009 SHALL have port: byte_en  in  DATA_WIDTH/8  write lane enables; sampled with req.
REQ-010 SHALL have port: data_in  in  DATA_WIDTH  write data; sampled with req.
REQ-011 SHALL have port: data_out  out  DATA_WIDTH  registered read data.
REQ-012 SHALL have port: ack  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port: parity_err  out  1  registered parity-error flag for the last read.

Function
REQ-015 SHALL implement FSM with states IDLE, WAIT, DONE.
REQ-016 SHALL, in IDLE with req=1, latch we/address/byte_en/data_in and go to WAIT (load counter = WAIT_STATES) if WAIT_STATES>0, else to DONE.
REQ-017 SHALL, in WAIT, decrement counter each cycle and go to DONE on the edge where counter = 1.
REQ-018 SHALL perform the memory access on the clock edge entering DONE, using latched inputs only.
REQ-019 SHALL assert ack for exactly the one cycle spent in DONE; DONE always returns to IDLE next cycle.
REQ-020 SHALL give req-to-ack latency of WAIT_STATES+1 cycles; max throughput is one access per WAIT_STATES+2 cycles.
REQ-021 SHALL ignore req, and all input changes, while busy=1; no queuing.
REQ-022 SHALL, on write, update only lanes with byte_en[i]=1 (bits 8i+7:8i); byte_en=0 is a legal no-op write that still acks.
REQ-023 SHALL, on read, load data_out with the full word (byte_en ignored); data_out holds until the next completed read; writes do not change data_out.
REQ-024 SHALL, for address >= RAM_SIZE, discard writes and return all-zeros on reads, still acking normally.
REQ-025 SHALL keep memory array contents uninitialised and unaffected by reset.

Reset
REQ-026 SHALL, on arst=1, immediately force state IDLE, counter 0, ack 0, busy 0, data_out 0, parity_err 0.
REQ-027 SHALL, when arst asserts before the edge entering DONE, cancel the pending access: no memory write, no ack.
REQ-028 SHALL accept a new req in the first clock cycle after arst deasserts.

Configuration
REQ-029 SHALL, with macro SYNC_RAM_PARITY_EN defined, store one even-parity bit per byte lane, written with its lane, and set parity_err in DONE of a read if any lane mismatches, clearing it in DONE of the next read with no mismatch.
REQ-030 SHALL, without SYNC_RAM_PARITY_EN, store no parity bits and tie parity_err to 0.

Verification (RAM_SIZE=256, DATA_WIDTH=16, WAIT_STATES=2 unless noted)
REQ-031 SHALL check: write 0xBEEF to addr 0x10, byte_en=11, then read addr 0x10 -> ack 3 cycles after each req, data_out=0xBEEF, busy high 3 cycles.
REQ-032 SHALL check: write 0x1234 to addr 5 with byte_en=01 over prior 0xBEEF, then read -> data_out=0xBE34.
REQ-033 SHALL check: pulse req again 1 cycle after an accepted req with addr 7 -> second req ignored, exactly one ack.
REQ-034 SHALL check: RAM_SIZE=200, write 0xAAAA to addr 210, then read addr 210 -> ack, data_out=0x0000, no array location changed.
REQ-035 SHALL check: assert arst in WAIT of a write of 0x5555 to addr 3 -> no ack, all outputs 0; later read of addr 3 returns its prior value.
REQ-036 SHALL check, with SYNC_RAM_PARITY_EN: force-flip bit 0 of stored word at addr 9 and read addr 9 -> parity_err=1 in DONE; clean read of addr 10 -> parity_err=0.
